// File: rtl/calc1_port_requester.sv
// Initiator-side driver for one calc1 request port: queues host operations,
// issues each as a cmd/op1 then op2 pair, and returns the response or a timeout.
module calc1_port_requester #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 31
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [3:0]  tx_cmd,
  input  logic [31:0] tx_op1,
  input  logic [31:0] tx_op2,
  output logic [3:0]  req_cmd_out,
  output logic [31:0] req_data_out,
  input  logic [1:0]  out_resp,
  input  logic [31:0] out_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [1:0]  rx_resp,
  output logic [31:0] rx_data,
  output logic [3:0]  rx_cmd,
  output logic        timeout,
  output logic        stray_resp,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, SEND1, SEND2, WAIT, HOLD} state_t;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
  } entry_t;

  entry_t      fifo_mem [DEPTH];
  entry_t      head;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        full, empty, push;

  state_t      state_q, state_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [31:0] op2_q, op2_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  req_cmd_q, req_cmd_d;
  logic [31:0] req_data_q, req_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic [1:0]  rx_resp_q, rx_resp_d;
  logic [31:0] rx_data_q, rx_data_d;
  logic [3:0]  rx_cmd_q, rx_cmd_d;
  logic        timeout_q, timeout_d;
  logic        stray_q, stray_d;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push     = tx_valid && !full;
  assign head     = fifo_mem[rd_ptr_q[AW-1:0]];
  assign tx_ready = !full;
  assign busy     = (state_q != IDLE) || !empty;

  always_ff @(posedge c_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q[AW-1:0]] <= '{cmd: tx_cmd, op1: tx_op1, op2: tx_op2};
    end
  end

  // Request outputs are computed for the state being entered so they are registered.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cmd_d      = cmd_q;
    op2_d      = op2_q;
    cnt_d      = cnt_q;
    req_cmd_d  = '0;
    req_data_d = '0;
    rx_valid_d = rx_valid_q;
    rx_resp_d  = rx_resp_q;
    rx_data_d  = rx_data_q;
    rx_cmd_d   = rx_cmd_q;
    timeout_d  = 1'b0;
    stray_d    = (out_resp != 2'd0) && (state_q != WAIT);

    case (state_q)
      IDLE: begin
        if (!empty) begin
          rd_ptr_d   = rd_ptr_q + PTR_ONE;
          cmd_d      = head.cmd;
          op2_d      = head.op2;
          req_cmd_d  = head.cmd;
          req_data_d = head.op1;
          state_d    = SEND1;
        end
      end
      SEND1: begin
        req_data_d = op2_q;
        state_d    = SEND2;
      end
      SEND2: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A response on the timeout edge still wins over the timeout.
        if (out_resp != 2'd0) begin
          rx_valid_d = 1'b1;
          rx_resp_d  = out_resp;
          rx_data_d  = out_data;
          rx_cmd_d   = cmd_q;
          state_d    = HOLD;
        end else if (cnt_q == TIMEOUT_CNT) begin
          rx_valid_d = 1'b1;
          rx_resp_d  = 2'd0;
          rx_data_d  = '0;
          rx_cmd_d   = cmd_q;
          timeout_d  = 1'b1;
          state_d    = HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        if (rx_ready) begin
          rx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cmd_q      <= '0;
      op2_q      <= '0;
      cnt_q      <= '0;
      req_cmd_q  <= '0;
      req_data_q <= '0;
      rx_valid_q <= 1'b0;
      rx_resp_q  <= '0;
      rx_data_q  <= '0;
      rx_cmd_q   <= '0;
      timeout_q  <= 1'b0;
      stray_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cmd_q      <= cmd_d;
      op2_q      <= op2_d;
      cnt_q      <= cnt_d;
      req_cmd_q  <= req_cmd_d;
      req_data_q <= req_data_d;
      rx_valid_q <= rx_valid_d;
      rx_resp_q  <= rx_resp_d;
      rx_data_q  <= rx_data_d;
      rx_cmd_q   <= rx_cmd_d;
      timeout_q  <= timeout_d;
      stray_q    <= stray_d;
    end
  end

  assign req_cmd_out  = req_cmd_q;
  assign req_data_out = req_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_resp      = rx_resp_q;
  assign rx_data      = rx_data_q;
  assign rx_cmd       = rx_cmd_q;
  assign timeout      = timeout_q;
  assign stray_resp   = stray_q;

endmodule
